// File: rtl/icache_axi_rd_bridge.sv
// Read-only bridge from the I-cache refill/uncached port to AXI4 AR/R channels.
// One request at a time becomes a single INCR burst; beats are returned registered.
module icache_axi_rd_bridge #(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rd_req,
  input  logic [2:0]      rd_type,
  input  logic [31:0]     rd_addr,
  output logic            rd_rdy,
  output logic            ret_valid,
  output logic            ret_last,
  output logic [63:0]     ret_data,
  output logic            ret_err,
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [ID_W-1:0] arid,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  input  logic            rvalid,
  output logic            rready,
  input  logic [63:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast
);

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  state_t     state, state_nxt;
  logic [7:0] beat_cnt;
  logic       beat;
  logic       beat_is_last;

  assign beat         = rvalid & rready;
  assign beat_is_last = (beat_cnt == arlen);
  assign arburst      = 2'b01;
  assign arid         = AXI_ID;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_rdy    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    case (state)
      IDLE: begin
        rd_rdy = 1'b1;
        if (rd_req) state_nxt = AR;
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = R;
      end
      R: begin
        rready = 1'b1;
        if (beat && beat_is_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // AR fields are captured once at acceptance, so they stay stable while arready is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      araddr <= '0;
      arlen  <= '0;
      arsize <= '0;
    end else if (state == IDLE && rd_req) begin
      if (rd_type[2]) begin
        araddr <= {rd_addr[31:4], 4'h0};
        arlen  <= 8'd1;
        arsize <= 3'd3;
      end else begin
        araddr <= rd_addr;
        arlen  <= 8'd0;
        arsize <= {1'b0, rd_type[1:0]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                beat_cnt <= '0;
    else if (state == IDLE)   beat_cnt <= '0;
    else if (beat)            beat_cnt <= beat_cnt + 8'd1;
  end

  // ret_last follows our own beat count; an rlast that disagrees is flagged as an error.
  always_ff @(posedge clock) begin
    if (reset) begin
      ret_valid <= 1'b0;
      ret_last  <= 1'b0;
      ret_err   <= 1'b0;
      ret_data  <= '0;
    end else begin
      ret_valid <= beat;
      ret_last  <= beat & beat_is_last;
      ret_err   <= beat & ((rresp != 2'b00) | (rlast != beat_is_last));
      if (beat) ret_data <= rdata;
    end
  end

endmodule
